// File: rtl/persiana_motor_driver.sv
// Motor output stage for the blind controller: turns level raise/lower requests into motor power and direction,
// with a dead-time interlock, limit refusal, travel timeout and optional PWM soft start.
// Latency: a request sampled on an edge in IDLE drives the outputs after that same edge; every output is registered.
// Backpressure: none. Requests that arrive during DEAD are dropped, not queued, and FAULT ignores everything until reset.
//
// Ports:
//   clk_i        single clock, rising edge
//   reset_i      synchronous, active-high reset
//   subir_i      raise request (level)
//   bajar_i      lower request (level)
//   ssup_i       upper limit sensor (1 = fully open)
//   sinf_i       lower limit sensor (1 = fully closed)
//   motor_en_o   motor power (PWM when soft start is compiled in)
//   motor_dir_o  1 = up, 0 = down; changes only while motor_en_o = 0
//   busy_o       high in RUN_UP, RUN_DN and DEAD
//   fault_o      sticky travel-timeout flag, cleared only by reset
//
// Optional feature: define PERSIANA_SOFT_START_EN to add the PWM duty ramp.

module persiana_motor_driver #(
   parameter int DEAD_CYCLES    = 16,
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int PWM_BITS       = 4
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic subir_i,
   input  logic bajar_i,
   input  logic ssup_i,
   input  logic sinf_i,
   output logic motor_en_o,
   output logic motor_dir_o,
   output logic busy_o,
   output logic fault_o
);

   localparam int RUN_W  = $clog2(TIMEOUT_CYCLES) + 1;
   localparam int DEAD_W = $clog2(DEAD_CYCLES) + 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RUN_UP = 3'd1,
      RUN_DN = 3'd2,
      DEAD   = 3'd3,
      FAULT  = 3'd4
   } state_t;

   state_t            state_q;
   logic [RUN_W-1:0]  run_cnt_q;
   logic [DEAD_W-1:0] dead_cnt_q;
   logic              en_q;
   logic              dir_q;
   logic              busy_q;
   logic              fault_q;

   logic up_req;
   logic dn_req;
   logic up_exit;
   logic dn_exit;
   logic run_last;
   logic dead_last;

   // A run may only start toward a limit that is not engaged; both requests high means stop.
   assign up_req  = subir_i & ~bajar_i & ~ssup_i;
   assign dn_req  = bajar_i & ~subir_i & ~sinf_i;
   assign up_exit = ~subir_i | bajar_i | ssup_i;
   assign dn_exit = ~bajar_i | subir_i | sinf_i;

   // Compare against limit-1 so the run holds the motor on for exactly TIMEOUT_CYCLES cycles.
   assign run_last  = (run_cnt_q == RUN_W'(TIMEOUT_CYCLES - 1));
   assign dead_last = (dead_cnt_q == DEAD_W'(DEAD_CYCLES - 1));

   // pwm_on_entry: motor_en value on the IDLE->RUN edge.
   // pwm_on_run: motor_en value for a cycle that stays in RUN.
   logic pwm_on_entry;
   logic pwm_on_run;

`ifdef PERSIANA_SOFT_START_EN
   localparam logic [PWM_BITS:0] DUTY_MAX = {1'b1, {PWM_BITS{1'b0}}};

   logic [PWM_BITS-1:0] pwm_cnt_q;
   logic [PWM_BITS-1:0] pwm_cnt_d;
   logic [PWM_BITS:0]   duty_q;
   logic [PWM_BITS:0]   duty_d;

   // Duty advances on the counter wrap, so each period runs at a constant duty.
   always_comb begin
      pwm_cnt_d = pwm_cnt_q + 1'b1;
      duty_d    = duty_q;
      if ((&pwm_cnt_q) && (duty_q != DUTY_MAX)) begin
         duty_d = duty_q + 1'b1;
      end
   end

   // Counter and duty both clear on entry, so the whole first period is off.
   assign pwm_on_entry = 1'b0;
   assign pwm_on_run   = ({1'b0, pwm_cnt_d} < duty_d);
`else
   assign pwm_on_entry = 1'b1;
   assign pwm_on_run   = 1'b1;
`endif

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= IDLE;
         run_cnt_q  <= '0;
         dead_cnt_q <= '0;
         en_q       <= 1'b0;
         dir_q      <= 1'b0;
         busy_q     <= 1'b0;
         fault_q    <= 1'b0;
`ifdef PERSIANA_SOFT_START_EN
         pwm_cnt_q  <= '0;
         duty_q     <= '0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (up_req || dn_req) begin
                  state_q   <= up_req ? RUN_UP : RUN_DN;
                  dir_q     <= up_req;
                  run_cnt_q <= '0;
                  en_q      <= pwm_on_entry;
                  busy_q    <= 1'b1;
`ifdef PERSIANA_SOFT_START_EN
                  pwm_cnt_q <= '0;
                  duty_q    <= '0;
`endif
               end
            end

            RUN_UP, RUN_DN: begin
               // Exit takes priority over the timeout on the same cycle.
               if ((state_q == RUN_UP) ? up_exit : dn_exit) begin
                  state_q    <= DEAD;
                  en_q       <= 1'b0;
                  dead_cnt_q <= '0;
               end else if (run_last) begin
                  state_q <= FAULT;
                  en_q    <= 1'b0;
                  busy_q  <= 1'b0;
                  fault_q <= 1'b1;
               end else begin
                  run_cnt_q <= run_cnt_q + 1'b1;
                  en_q      <= pwm_on_run;
`ifdef PERSIANA_SOFT_START_EN
                  pwm_cnt_q <= pwm_cnt_d;
                  duty_q    <= duty_d;
`endif
               end
            end

            DEAD: begin
               if (dead_last) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  dead_cnt_q <= dead_cnt_q + 1'b1;
               end
            end

            FAULT: begin
               en_q    <= 1'b0;
               busy_q  <= 1'b0;
               fault_q <= 1'b1;
            end

            default: begin
               state_q <= IDLE;
               en_q    <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign motor_en_o  = en_q;
   assign motor_dir_o = dir_q;
   assign busy_o      = busy_q;
   assign fault_o     = fault_q;

endmodule

// File: tb/tb_persiana_motor_driver.sv
// Directed bench for persiana_motor_driver with DEAD=4, TIMEOUT=20, PWM_BITS=2.
// Inputs are driven, one rising edge passes, and the outputs are sampled 1ns later.
// When soft start is compiled in, motor_en is checked only in the dedicated ramp sequence.

module tb_persiana_motor_driver;

   localparam int DEAD = 4;
   localparam int TMO  = 20;
   localparam int PB   = 2;

`ifdef PERSIANA_SOFT_START_EN
   localparam bit SOFT = 1'b1;
`else
   localparam bit SOFT = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic subir = 1'b0;
   logic bajar = 1'b0;
   logic ssup = 1'b0;
   logic sinf = 1'b0;
   logic motor_en;
   logic motor_dir;
   logic busy;
   logic fault;

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   persiana_motor_driver #(
      .DEAD_CYCLES(DEAD),
      .TIMEOUT_CYCLES(TMO),
      .PWM_BITS(PB)
   ) dut (
      .clk_i(clk),
      .reset_i(reset),
      .subir_i(subir),
      .bajar_i(bajar),
      .ssup_i(ssup),
      .sinf_i(sinf),
      .motor_en_o(motor_en),
      .motor_dir_o(motor_dir),
      .busy_o(busy),
      .fault_o(fault)
   );

   typedef struct packed {
      logic rst;
      logic sub;
      logic baj;
      logic sup;
      logic inf;
      logic en;
      logic dir;
      logic bsy;
      logic flt;
   } vec_t;

   localparam int NV = 29;
   vec_t tbl [NV];

   task automatic chk(input string nm, input int idx, input logic act, input logic exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s step %0d: got %b expected %b", nm, idx, act, exp);
      end
   endtask

   task automatic step(input logic r, input logic s, input logic b, input logic u, input logic l);
      reset = r;
      subir = s;
      bajar = b;
      ssup  = u;
      sinf  = l;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Bit order: rst sub baj sup inf | en dir busy fault (values after the edge)
      tbl[0]  = 9'b1_0000_0000; // reset
      tbl[1]  = 9'b0_0000_0000; // idle, no request
      tbl[2]  = 9'b0_1000_1110; // up request -> RUN_UP
      tbl[3]  = 9'b0_1000_1110;
      tbl[4]  = 9'b0_1000_1110;
      tbl[5]  = 9'b0_1000_1110;
      tbl[6]  = 9'b0_1000_1110;
      tbl[7]  = 9'b0_1010_0110; // upper limit -> DEAD, motor off
      tbl[8]  = 9'b0_1010_0110;
      tbl[9]  = 9'b0_1010_0110;
      tbl[10] = 9'b0_1010_0110;
      tbl[11] = 9'b0_1010_0100; // IDLE four edges after the exit
      tbl[12] = 9'b0_1010_0100; // up into engaged limit refused
      tbl[13] = 9'b0_0100_1010; // down request -> RUN_DN, dir 0
      tbl[14] = 9'b0_0100_1010;
      tbl[15] = 9'b0_1000_0010; // reversal -> DEAD, dir held
      tbl[16] = 9'b0_1000_0010; // request during DEAD ignored
      tbl[17] = 9'b0_1000_0010;
      tbl[18] = 9'b0_1000_0010;
      tbl[19] = 9'b0_1000_0000; // IDLE, still off, dir unchanged
      tbl[20] = 9'b0_1000_1110; // up run after DEAD+1 off cycles
      tbl[21] = 9'b0_1100_0110; // both requests -> stop
      tbl[22] = 9'b0_0000_0110;
      tbl[23] = 9'b0_0000_0110;
      tbl[24] = 9'b0_0000_0110;
      tbl[25] = 9'b0_0000_0100;
      tbl[26] = 9'b0_1000_1110; // up run again
      tbl[27] = 9'b1_1000_0000; // reset mid-run
      tbl[28] = 9'b0_0000_0000;

      for (int i = 0; i < NV; i++) begin
         step(tbl[i].rst, tbl[i].sub, tbl[i].baj, tbl[i].sup, tbl[i].inf);
         if (!SOFT) chk("motor_en", i, motor_en, tbl[i].en);
         chk("motor_dir", i, motor_dir, tbl[i].dir);
         chk("busy", i, busy, tbl[i].bsy);
         chk("fault", i, fault, tbl[i].flt);
      end

      // Timeout: bajar held with sinf=0; 20 run cycles, then FAULT on the 21st edge.
      step(1, 0, 0, 0, 0);
      for (int k = 1; k <= TMO; k++) begin
         step(0, 0, 1, 0, 0);
         chk("tmo_busy", k, busy, 1'b1);
         chk("tmo_fault_early", k, fault, 1'b0);
         if (!SOFT) chk("tmo_en", k, motor_en, 1'b1);
      end
      for (int k = 0; k < 10; k++) begin
         step(0, 0, 1, 0, 0);
         chk("flt_fault", k, fault, 1'b1);
         chk("flt_en", k, motor_en, 1'b0);
         chk("flt_busy", k, busy, 1'b0);
      end
      step(1, 0, 1, 0, 0);
      chk("flt_reset_fault", 0, fault, 1'b0);
      chk("flt_reset_dir", 0, motor_dir, 1'b0);
      step(0, 0, 0, 0, 0);
      chk("flt_after_reset", 0, fault, 1'b0);

      // Soft-start ramp: in period p the motor is on min(p,4) of 4 cycles; solid without the macro.
      for (int k = 0; k < TMO; k++) begin
         int  p;
         int  ph;
         int  duty;
         logic exp_en;
         p    = k / (1 << PB);
         ph   = k % (1 << PB);
         duty = (p > (1 << PB)) ? (1 << PB) : p;
         exp_en = SOFT ? (ph < duty) : 1'b1;
         step(0, 1, 0, 0, 0);
         chk("ramp_en", k, motor_en, exp_en);
         chk("ramp_dir", k, motor_dir, 1'b1);
      end
      step(0, 0, 0, 0, 0);
      chk("ramp_stop_en", 0, motor_en, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/persiana_motor_driver.md
# persiana_motor_driver

Downstream stage of the blind controller FSM: consumes the FSM's `subir`/`bajar` requests and the end-of-travel sensors, and drives the physical motor outputs. It enforces a dead-time interlock between direction changes, refuses motion into an engaged limit, aborts on a travel timeout, and optionally soft-starts the motor through a PWM duty ramp. All outputs are registered and safe (motor off) out of reset.

## Interface
- `DEAD_CYCLES`, default 16: motor-off interval after any run ends, in `clk` cycles (≥1).
- `TIMEOUT_CYCLES`, default 1000: maximum cycles in one run before a fault (≥2).
- `PWM_BITS`, default 4: PWM period is 2^PWM_BITS cycles; soft-start ramp resolution.

- `clk`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `subir`  in  1  raise request from the FSM, level.
- `bajar`  in  1  lower request from the FSM, level.
- `ssup`  in  1  upper limit sensor, 1 = fully open.
- `sinf`  in  1  lower limit sensor, 1 = fully closed.
- `motor_en`  out  1  motor power (PWM when soft start is compiled in).
- `motor_dir`  out  1  1 = up, 0 = down; only changes while `motor_en`=0.
- `busy`  out  1  1 in RUN_UP, RUN_DN or DEAD.
- `fault`  out  1  sticky travel-timeout flag.

## Operation
- States: IDLE, RUN_UP, RUN_DN, DEAD, FAULT.
- Valid up request: `subir`=1, `bajar`=0, `ssup`=0. Valid down request: `bajar`=1, `subir`=0, `sinf`=0. Both requests high = stop request.
- IDLE: valid up → RUN_UP (`motor_dir`←1); valid down → RUN_DN (`motor_dir`←0); otherwise stay.
- RUN_UP: leave to DEAD when `subir`=0, `bajar`=1, or `ssup`=1. RUN_DN symmetric with `bajar`/`subir`/`sinf`.
- Run counter clears on entry to RUN_x, increments each cycle in RUN_x; if it reaches TIMEOUT_CYCLES while no exit condition holds → FAULT. Exit condition and timeout on the same cycle: exit wins (→ DEAD).
- DEAD: motor off, dead counter counts DEAD_CYCLES cycles, then → IDLE. Requests during DEAD are ignored (not queued); a request still held on IDLE entry is acted on one cycle later.
- FAULT: motor off, `fault`=1, `busy`=0; left only by `reset`.
- `motor_dir` holds its last value outside RUN states; it is updated only on the IDLE→RUN_x transition.
- Counter widths: `$clog2` of their limit + 1; no wrap is reachable.

## Timing
- Reset values: state IDLE, `motor_en`=0, `motor_dir`=0, `busy`=0, `fault`=0, all counters 0. Reset mid-run stops the motor on the next edge.
- Request sampled at edge N in IDLE → state RUN_x and `busy`=1 after edge N; `motor_en` first high after edge N (no PWM) or per ramp (PWM).
- Exit condition at edge N → `motor_en`=0, state DEAD after edge N; IDLE after edge N+DEAD_CYCLES.
- Minimum off time between any two runs, including reversals: DEAD_CYCLES+1 cycles.
- Timeout: FAULT after edge where run counter = TIMEOUT_CYCLES, i.e. run of exactly TIMEOUT_CYCLES cycles with motor on.

## Configuration
- `PERSIANA_SOFT_START_EN` defined: PWM counter (PWM_BITS) and duty register (PWM_BITS+1) clear on RUN_x entry; PWM counter free-runs in RUN_x; duty increments by 1 each time the PWM counter wraps, saturating at 2^PWM_BITS; `motor_en` = RUN_x and ({0,pwm_cnt} < duty). First period fully off; full on after 2^PWM_BITS periods.
- Not defined: no PWM logic; `motor_en` = 1 for every cycle in RUN_x, 0 elsewhere.

## Test plan
- Reset, then `subir`=1 (`ssup`=0), DEAD=4, TIMEOUT=20 → `motor_dir`=1, `busy`=1 next cycle; `ssup`=1 after 5 cycles → `motor_en`=0 next cycle, IDLE 4 cycles later.
- Running down, switch to `subir`=1,`bajar`=0 → motor off ≥5 cycles, `motor_dir` changes only while off, then up run.
- `subir`=1 with `ssup`=1 in IDLE → stays IDLE, `motor_en` never 1; `subir`=`bajar`=1 mid-run → DEAD.
- Hold `bajar`=1, `sinf`=0 for 30 cycles, TIMEOUT=20 → `fault`=1 after 20 run cycles, motor off, stays FAULT until `reset`; fault clears on reset cycle.
- `PERSIANA_SOFT_START_EN`, PWM_BITS=2: motor on 0,1,2,3 of 4 cycles in periods 1–4, constantly on from period 5; without macro `motor_en` solid.
- Assert `reset` while RUN_UP with `motor_en`=1 → all outputs at reset values after that edge.
